// File: rtl/key_scan_encoder.sv
// PS/2 set-2 keypad decoder: strips E0/F0 prefixes, maps make codes to calculator
// keys, suppresses typematic repeats and keeps a four-entry history of key codes.
module key_scan_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  scan_byte,
    input  logic        scan_valid,
    output logic [3:0]  key_code,
    output logic        key_strobe,
    output logic [15:0] digits,
    output logic        clr_strobe
);

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CODE_W   = 4;
    localparam int unsigned DIGITS_W = 4 * CODE_W;

    localparam logic [BYTE_W-1:0]   PFX_EXT   = 8'hE0;
    localparam logic [BYTE_W-1:0]   PFX_BRK   = 8'hF0;
    localparam logic [BYTE_W-1:0]   SCAN_ESC  = 8'h76;
    localparam logic [CODE_W-1:0]   CODE_NONE = 4'hF;
    localparam logic [DIGITS_W-1:0] DIGITS_BLANK = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    typedef struct packed {
        logic              hit;
        logic              esc;
        logic [CODE_W-1:0] code;
    } key_map_t;

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   held_scan_q, held_scan_d;
    logic                held_valid_q, held_valid_d;
    logic [CODE_W-1:0]   key_code_d;
    logic [DIGITS_W-1:0] digits_d;
    logic                key_strobe_d;
    logic                clr_strobe_d;
    key_map_t            map_c;
    logic                accept_c;

    // Fixed make-code map; main-block and keypad scan codes share a key.
    function automatic key_map_t map_make(input logic [BYTE_W-1:0] b);
        key_map_t m;
        m.hit  = 1'b1;
        m.esc  = 1'b0;
        m.code = CODE_NONE;
        case (b)
            8'h45, 8'h70: m.code = 4'd0;
            8'h16, 8'h69: m.code = 4'd1;
            8'h1E, 8'h72: m.code = 4'd2;
            8'h26, 8'h7A: m.code = 4'd3;
            8'h25, 8'h6B: m.code = 4'd4;
            8'h2E, 8'h73: m.code = 4'd5;
            8'h36, 8'h74: m.code = 4'd6;
            8'h3D, 8'h6C: m.code = 4'd7;
            8'h3E, 8'h75: m.code = 4'd8;
            8'h46, 8'h7D: m.code = 4'd9;
            8'h1C, 8'h79: m.code = 4'd10;
            8'h1B, 8'h7B: m.code = 4'd11;
            8'h3A, 8'h7C: m.code = 4'd12;
            SCAN_ESC:     m.esc  = 1'b1;
            default:      m.hit  = 1'b0;
        endcase
        return m;
    endfunction

    assign map_c    = map_make(scan_byte);
    // A make is taken unless it repeats the key that is still held down.
    assign accept_c = map_c.hit && (!held_valid_q || (scan_byte != held_scan_q));

    // State register plus all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            held_scan_q  <= '0;
            held_valid_q <= 1'b0;
            key_code     <= CODE_NONE;
            digits       <= DIGITS_BLANK;
            key_strobe   <= 1'b0;
            clr_strobe   <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_scan_q  <= held_scan_d;
            held_valid_q <= held_valid_d;
            key_code     <= key_code_d;
            digits       <= digits_d;
            key_strobe   <= key_strobe_d;
            clr_strobe   <= clr_strobe_d;
        end
    end

    // Prefix FSM next-state and register updates.
    always_comb begin
        state_d      = state_q;
        held_scan_d  = held_scan_q;
        held_valid_d = held_valid_q;
        key_code_d   = key_code;
        digits_d     = digits;
        key_strobe_d = 1'b0;
        clr_strobe_d = 1'b0;

        if (scan_valid) begin
            case (state_q)
                IDLE: begin
                    if (scan_byte == PFX_EXT) begin
                        state_d = EXT;
                    end else if (scan_byte == PFX_BRK) begin
                        state_d = BRK;
                    end else if (accept_c) begin
                        held_scan_d  = scan_byte;
                        held_valid_d = 1'b1;
                        if (map_c.esc) begin
                            digits_d     = DIGITS_BLANK;
                            key_code_d   = CODE_NONE;
                            clr_strobe_d = 1'b1;
                        end else begin
                            key_code_d   = map_c.code;
                            digits_d     = {digits[DIGITS_W-CODE_W-1:0], map_c.code};
                            key_strobe_d = 1'b1;
                        end
                    end
                end
                EXT: begin
                    if (scan_byte == PFX_BRK) begin
                        state_d = EXT_BRK;
                    end else if (scan_byte == PFX_EXT) begin
                        state_d = EXT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    // Releasing the held key re-arms it; other releases are ignored.
                    if (scan_byte == held_scan_q) begin
                        held_valid_d = 1'b0;
                    end
                    state_d = IDLE;
                end
                EXT_BRK: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_scan_encoder.sv
// Directed bench for key_scan_encoder: byte sequences with hand-computed
// key codes, digit history and strobe counts.
module tb_key_scan_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  scan_byte = 8'h00;
    logic        scan_valid = 1'b0;
    logic [3:0]  key_code;
    logic        key_strobe;
    logic [15:0] digits;
    logic        clr_strobe;

    int n_checks = 0;
    int n_fail   = 0;
    int n_key    = 0;
    int n_clr    = 0;
    int n_both   = 0;
    int k0, c0;

    key_scan_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_byte  (scan_byte),
        .scan_valid (scan_valid),
        .key_code   (key_code),
        .key_strobe (key_strobe),
        .digits     (digits),
        .clr_strobe (clr_strobe)
    );

    always #5 clk = ~clk;

    // Strobe counters sampled mid-cycle.
    always @(negedge clk) begin
        if (key_strobe) n_key++;
        if (clr_strobe) n_clr++;
        if (key_strobe && clr_strobe) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_byte  = b;
        scan_valid = 1'b1;
    endtask

    task automatic settle();
        @(negedge clk);
        scan_valid = 1'b0;
        scan_byte  = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        scan_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic key(input logic [7:0] b);
        send(b); send(8'hF0); send(b);
    endtask

    task automatic snap();
        k0 = n_key;
        c0 = n_clr;
    endtask

    initial begin
        // Asynchronous reset before any clock edge matters.
        #2 rst_n = 1'b0;
        #1;
        check("rst_key_code", 32'(key_code), 32'hF);
        check("rst_digits", 32'(digits), 32'hFFFF);
        check("rst_key_strobe", 32'(key_strobe), 32'h0);
        check("rst_clr_strobe", 32'(clr_strobe), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Press and release 1, then press again once released.
        snap();
        send(8'h16); send(8'hF0); send(8'h16); settle();
        check("t24_strobes", 32'(n_key - k0), 32'd1);
        check("t24_key_code", 32'(key_code), 32'd1);
        check("t24_digits", 32'(digits), 32'hFFF1);
        snap();
        send(8'h16); settle();
        check("t24_rearm_strobes", 32'(n_key - k0), 32'd1);
        check("t24_rearm_digits", 32'(digits), 32'hFF11);

        // Typematic repeat of 2 is suppressed until released.
        do_reset();
        snap();
        send(8'h1E); send(8'h1E); send(8'h1E); send(8'hF0); send(8'h1E); send(8'h1E); settle();
        check("t25_strobes", 32'(n_key - k0), 32'd2);
        check("t25_digits", 32'(digits), 32'hFF22);

        // Five keys shift out the oldest; keypad + maps to add.
        do_reset();
        key(8'h16); key(8'h1E); key(8'h26); key(8'h25); key(8'h2E); settle();
        check("t26_digits_5", 32'(digits), 32'h2345);
        key(8'h79); settle();
        check("t26_digits_add", 32'(digits), 32'h345A);
        check("t26_key_code", 32'(key_code), 32'd10);

        // Extended make and break are ignored; following M is taken.
        do_reset();
        snap();
        send(8'hE0); send(8'h70); send(8'hE0); send(8'hF0); send(8'h70); settle();
        check("t27_ext_strobes", 32'(n_key - k0), 32'd0);
        check("t27_ext_digits", 32'(digits), 32'hFFFF);
        check("t27_ext_key_code", 32'(key_code), 32'hF);
        snap();
        send(8'h7C); settle();
        check("t27_mult_strobes", 32'(n_key - k0), 32'd1);
        check("t27_mult_key_code", 32'(key_code), 32'd12);

        // Esc clears the history.
        do_reset();
        key(8'h45); key(8'h45); key(8'h16); key(8'h1E); settle();
        check("t28_digits_pre", 32'(digits), 32'h0012);
        snap();
        key(8'h76); settle();
        check("t28_clr_strobes", 32'(n_clr - c0), 32'd1);
        check("t28_key_strobes", 32'(n_key - k0), 32'd0);
        check("t28_digits", 32'(digits), 32'hFFFF);
        check("t28_key_code", 32'(key_code), 32'hF);

        // Unmapped makes, extended makes and foreign breaks keep the held key.
        do_reset();
        send(8'h16); settle();
        snap();
        send(8'h0D); send(8'h16); send(8'hE0); send(8'hE0); send(8'h45);
        send(8'hF0); send(8'h1E); send(8'h16); settle();
        check("unmapped_strobes", 32'(n_key - k0), 32'd0);
        check("unmapped_digits", 32'(digits), 32'hFFF1);
        snap();
        send(8'h0D); send(8'h46); settle();
        check("after_unmapped_strobes", 32'(n_key - k0), 32'd1);
        check("after_unmapped_digits", 32'(digits), 32'hFF19);

        // Reset mid-break discards the prefix; strobe lands one cycle later.
        do_reset();
        send(8'h16); settle();
        send(8'hF0);
        @(negedge clk);
        scan_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t29_async_digits", 32'(digits), 32'hFFFF);
        check("t29_async_key_code", 32'(key_code), 32'hF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap();
        send(8'h45);
        @(negedge clk);
        scan_valid = 1'b0;
        check("t29_strobe_timing", 32'(key_strobe), 32'h1);
        check("t29_key_code", 32'(key_code), 32'd0);
        repeat (3) @(negedge clk);
        check("t29_strobes", 32'(n_key - k0), 32'd1);
        check("t29_digits", 32'(digits), 32'hFFF0);
        check("strobe_exclusive", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_scan_encoder.md
KEY_SCAN_ENCODER -- requirements
Module: key_scan_encoder

Interface
REQ-001 The block SHALL have no parameters; the code map is fixed by REQ-012.
REQ-002 Port clk: input, 1 bit, sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-004 Port scan_byte: input, 8 bits, PS/2 set-2 byte from the upstream receiver.
REQ-005 Port scan_valid: input, 1 bit, one-cycle strobe qualifying scan_byte; scan_byte is ignored when low.
REQ-006 Port key_code: output, 4 bits, registered code of the last accepted key (0-9 digit, 10 add, 11 sub, 12 mult, 15 none).
REQ-007 Port key_strobe: output, 1 bit, one-cycle pulse when key_code is updated.
REQ-008 Port digits: output, 16 bits, four 4-bit codes of the last keys; [3:0] is newest; 4'hF means blank.
REQ-009 Port clr_strobe: output, 1 bit, one-cycle pulse when the Esc key clears digits.

Function
REQ-010 The prefix FSM SHALL have states IDLE, EXT (E0 seen), BRK (F0 seen) and EXT_BRK (E0 then F0 seen), and SHALL change state only on cycles with scan_valid high.
REQ-011 The FSM transitions SHALL be:
- IDLE: E0 -> EXT; F0 -> BRK; other byte -> make event, stay IDLE.
- EXT: F0 -> EXT_BRK; E0 -> EXT; other byte -> extended make, IDLE.
- BRK: any byte -> break event, IDLE.
- EXT_BRK: any byte -> extended break, IDLE.
REQ-012 The non-extended make map SHALL be:
- 45/70 -> 0; 16/69 -> 1; 1E/72 -> 2; 26/7A -> 3; 25/6B -> 4; 2E/73 -> 5; 36/74 -> 6; 3D/6C -> 7; 3E/75 -> 8; 46/7D -> 9.
- 1C/79 -> 10 (A, add); 1B/7B -> 11 (S, sub); 3A/7C -> 12 (M, mult).
- 76 (Esc) -> clear.
- All other bytes, and all extended makes, -> unmapped.
REQ-013 The block SHALL hold an 8-bit held-scan register and a held-valid flag.
REQ-014 On a mapped make whose byte differs from held-scan, or when held-valid is low, the block SHALL take these actions:
- Load held-scan and set held-valid.
- For a code key: register key_code; shift digits left by 4 with the new code into [3:0]; pulse key_strobe in the next cycle.
- For Esc: set digits to 16'hFFFF; set key_code to 15; pulse clr_strobe.
REQ-015 Typematic suppression: a make that equals held-scan while held-valid is high SHALL produce no strobe and no register change.
REQ-016 A non-extended break whose byte equals held-scan SHALL clear held-valid; any other break SHALL be ignored.
REQ-017 Extended makes and extended breaks SHALL never change key_code, digits or the held-scan state.
REQ-018 Unmapped makes SHALL produce no strobe, SHALL leave held-scan unchanged and SHALL return the FSM to IDLE.
REQ-019 key_strobe and clr_strobe SHALL be mutually exclusive, each one cycle wide, and SHALL assert one cycle after the accepting scan_valid cycle.
REQ-020 Back-to-back scan_valid on consecutive cycles SHALL be processed without loss.
REQ-021 The oldest code ([15:12]) SHALL be discarded on each shift.

Reset
REQ-022 While rst_n is low, the block SHALL force the following values immediately, regardless of clk:
- FSM = IDLE.
- key_code = 4'hF.
- key_strobe = 0 and clr_strobe = 0.
- digits = 16'hFFFF.
- held-scan = 8'h00 and held-valid = 0.
REQ-023 If reset asserts mid-sequence (after E0 or F0), the pending prefix SHALL be discarded, and after release the next byte SHALL be decoded from IDLE.

Verification
REQ-024 Bytes 16, F0, 16 -> one key_strobe; key_code = 1; digits = 16'hFFF1; held-valid = 0 after the break.
REQ-025 Bytes 1E, 1E, 1E, F0, 1E, 1E -> exactly two key_strobe pulses, digits = 16'hFF22.
REQ-026 Keys 1, 2, 3, 4, 5 (each with its break) -> digits = 16'h2345; then 79, F0, 79 -> digits = 16'h345A, key_code = 10.
REQ-027 Bytes E0, 70, E0, F0, 70, then 7C -> no strobe on the extended pair; a single key_strobe with key_code = 12.
REQ-028 With digits = 16'h0012, bytes 76, F0, 76 -> clr_strobe pulses once, digits = 16'hFFFF, key_code = 15, key_strobe stays low.
REQ-029 Byte F0, then rst_n low for 2 cycles and released, then byte 45 -> key_strobe with key_code = 0, not treated as a break.
